// File: rtl/rect_fill_writer_if.sv
// Command and frame-buffer write signals for rect_fill_writer.
// master: command source / write port side; slave: the fill writer.
interface rect_fill_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [7:0]  cmd_x1;
    logic [6:0]  cmd_y0;
    logic [6:0]  cmd_y1;
    logic [3:0]  cmd_color;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ready;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, wr_ready,
        input  cmd_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, wr_ready,
        output cmd_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rect_fill_writer.sv
// Rectangle-fill frame-buffer writer: one write per covered pixel, row-major,
// addr = y*Width + x, matching the scan-out address mapping.
module rect_fill_writer #(
    parameter int unsigned Width  = 160,
    parameter int unsigned Height = 120
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rect_fill_writer_if.slave   bus,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [7:0]  XMax    = 8'(Width - 1);
    localparam logic [6:0]  YMax    = 7'(Height - 1);
    localparam logic [14:0] Width15 = 15'(Width);

    typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} state_e;

    state_e      state_q;
    logic [7:0]  x0_q, x1_q, cur_x_q;
    logic [6:0]  y0_q, y1_q, cur_y_q;
    logic [3:0]  color_q;
    logic [14:0] row_base_q;
    logic        cmd_ready_q, wr_en_q, busy_q, done_q;
    logic [14:0] wr_addr_q;
    logic [3:0]  wr_data_q;

    logic [7:0]  x0_clip, x1_clip, next_x;
    logic [6:0]  y0_clip, y1_clip;
    logic [14:0] row0, next_base;
    logic        empty;

    // Saturating clip of the latched corners and the adds used while filling.
    always_comb begin
        x0_clip   = (x0_q > XMax) ? XMax : x0_q;
        x1_clip   = (x1_q > XMax) ? XMax : x1_q;
        y0_clip   = (y0_q > YMax) ? YMax : y0_q;
        y1_clip   = (y1_q > YMax) ? YMax : y1_q;
        empty     = (x0_clip > x1_clip) || (y0_clip > y1_clip);
        row0      = 15'(y0_clip) * Width15;
        next_x    = cur_x_q + 8'd1;
        next_base = row_base_q + Width15;
    end

    // Command FSM with registered outputs; a write advances only when wr_ready is high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            color_q     <= '0;
            row_base_q  <= '0;
            cmd_ready_q <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        x0_q        <= bus.cmd_x0;
                        x1_q        <= bus.cmd_x1;
                        y0_q        <= bus.cmd_y0;
                        y1_q        <= bus.cmd_y1;
                        color_q     <= bus.cmd_color;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    // Keep the clipped bounds so FILL compares against on-screen limits.
                    x0_q <= x0_clip;
                    x1_q <= x1_clip;
                    y0_q <= y0_clip;
                    y1_q <= y1_clip;
                    if (empty) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cur_x_q    <= x0_clip;
                        cur_y_q    <= y0_clip;
                        row_base_q <= row0;
                        wr_addr_q  <= row0 + 15'(x0_clip);
                        wr_data_q  <= color_q;
                        wr_en_q    <= 1'b1;
                        state_q    <= StFill;
                    end
                end
                StFill: begin
                    if (bus.wr_ready) begin
                        if (cur_x_q < x1_q) begin
                            cur_x_q   <= next_x;
                            wr_addr_q <= row_base_q + 15'(next_x);
                        end else if (cur_y_q < y1_q) begin
                            cur_x_q    <= x0_q;
                            cur_y_q    <= cur_y_q + 7'd1;
                            row_base_q <= next_base;
                            wr_addr_q  <= next_base + 15'(x0_q);
                        end else begin
                            wr_en_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Bench for rect_fill_writer: directed table, scripted stall/reset sequences and
// random commands checked against a loop-based pixel-list model.
module tb_rect_fill_writer;

    localparam int W = 160;
    localparam int H = 120;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];

    rect_fill_writer_if bus ();

    rect_fill_writer #(.Width(W), .Height(H)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .busy_o (busy),
        .done_o (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, x1, y0, y1, color;
        int mode, stall_k, stall_len;
        int exp_n, exp_first, exp_last, exp_done;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected address list: clip each corner, then walk rows top to bottom.
    task automatic model(input int x0, input int x1, input int y0, input int y1);
        int cx0, cx1, cy0, cy1;
        exp_q.delete();
        cx0 = (x0 > W - 1) ? W - 1 : x0;
        cx1 = (x1 > W - 1) ? W - 1 : x1;
        cy0 = (y0 > H - 1) ? H - 1 : y0;
        cy1 = (y1 > H - 1) ? H - 1 : y1;
        for (int y = cy0; y <= cy1; y++)
            for (int x = cx0; x <= cx1; x++)
                exp_q.push_back(y * W + x);
    endtask

    // mode 0: wr_ready always 1; 1: random; 2: hold low stall_len cycles at write stall_k
    task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                           input int color, input int mode, input int stall_k,
                           input int stall_len, output int n, output int first_a,
                           output int last_a, output int done_cyc);
        int stalls, sl, cyc;
        logic prev_stall, rdy;
        logic [14:0] prev_addr;
        logic [3:0]  prev_data;
        model(x0, x1, y0, y1);
        n = 0; first_a = -1; last_a = -1; done_cyc = -1;
        stalls = 0; sl = stall_len; cyc = 0; prev_stall = 1'b0;
        prev_addr = '0; prev_data = '0;
        @(negedge clk);
        check("ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_x0 = 8'(x0); bus.cmd_x1 = 8'(x1);
        bus.cmd_y0 = 7'(y0); bus.cmd_y1 = 7'(y1);
        bus.cmd_color = 4'(color);
        bus.cmd_valid = 1'b1;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.cmd_valid = 1'b0;
                check("setup_wr_en", {31'd0, bus.wr_en}, 32'd0);
            end
            check("busy_in_cmd", {31'd0, busy}, 32'd1);
            check("ready_low_in_cmd", {31'd0, bus.cmd_ready}, 32'd0);
            if (prev_stall) begin
                check("stall_hold_en", {31'd0, bus.wr_en}, 32'd1);
                check("stall_hold_addr", {17'd0, bus.wr_addr}, {17'd0, prev_addr});
                check("stall_hold_data", {28'd0, bus.wr_data}, {28'd0, prev_data});
            end
            rdy = 1'b1;
            if (bus.wr_en) begin
                if (n < exp_q.size()) begin
                    check("wr_addr", {17'd0, bus.wr_addr}, exp_q[n]);
                    check("wr_data", {28'd0, bus.wr_data}, color);
                end else begin
                    check("extra_write", {31'd0, bus.wr_en}, 32'd0);
                end
                if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
                else if (mode == 2 && n == stall_k && sl > 0) begin
                    rdy = 1'b0;
                    sl--;
                end
                if (rdy) begin
                    if (n == 0) first_a = int'(bus.wr_addr);
                    last_a = int'(bus.wr_addr);
                    n++;
                end else begin
                    stalls++;
                end
                prev_addr = bus.wr_addr;
                prev_data = bus.wr_data;
            end
            prev_stall = bus.wr_en && !rdy;
            bus.wr_ready = rdy;
            if (done) done_cyc = cyc;
        end
        bus.wr_ready = 1'b1;
        check("write_count", n, exp_q.size());
        check("done_cycle", done_cyc, exp_q.size() + 2 + stalls);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, bus.cmd_ready}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int n, fa, la, dc, cnt;
        vecs[0] = '{3, 3, 2, 2, 5, 0, 0, 0, 1, 323, 323, 3};
        vecs[1] = '{158, 159, 118, 119, 15, 0, 0, 0, 4, 19038, 19199, 6};
        vecs[2] = '{150, 200, 0, 0, 10, 0, 0, 0, 10, 150, 159, 12};
        vecs[3] = '{10, 4, 0, 0, 3, 0, 0, 0, 0, -1, -1, 2};
        vecs[4] = '{0, 2, 1, 1, 7, 2, 1, 3, 3, 160, 162, 8};
        vecs[5] = '{0, 1, 126, 127, 2, 0, 0, 0, 2, 19040, 19041, 4};
        vecs[6] = '{200, 255, 3, 3, 1, 0, 0, 0, 1, 639, 639, 3};

        bus.cmd_valid = 1'b0; bus.cmd_x0 = '0; bus.cmd_x1 = '0;
        bus.cmd_y0 = '0; bus.cmd_y1 = '0; bus.cmd_color = '0; bus.wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("rst_wr_addr", {17'd0, bus.wr_addr}, 32'd0);
        check("rst_wr_data", {28'd0, bus.wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1, vecs[i].color,
                    vecs[i].mode, vecs[i].stall_k, vecs[i].stall_len, n, fa, la, dc);
            check($sformatf("vec%0d_n", i), n, vecs[i].exp_n);
            check($sformatf("vec%0d_first", i), fa, vecs[i].exp_first);
            check($sformatf("vec%0d_last", i), la, vecs[i].exp_last);
            if (vecs[i].mode != 1) check($sformatf("vec%0d_done", i), dc, vecs[i].exp_done);
        end

        // Reset in the middle of a 4x4 fill.
        @(negedge clk);
        bus.cmd_x0 = 8'd10; bus.cmd_x1 = 8'd13; bus.cmd_y0 = 7'd5; bus.cmd_y1 = 7'd8;
        bus.cmd_color = 4'd6; bus.cmd_valid = 1'b1; bus.wr_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50 && cnt < 5; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (bus.wr_en) cnt++;
        end
        check("abort_writes_seen", cnt, 5);
        @(negedge clk);
        rst_n = 1'b0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        check("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        rst_n = 1'b1;
        bus.wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_idle", {30'd0, bus.wr_en, done}, 32'd0);
        end
        run_cmd(1, 1, 1, 1, 9, 0, 0, 0, n, fa, la, dc);
        check("post_abort_addr", fa, 161);
        check("post_abort_done", dc, 3);

        // Random commands with random write back-pressure.
        for (int t = 0; t < 40; t++) begin
            int x0, x1, y0, y1;
            x0 = $urandom_range(0, 255);
            y0 = $urandom_range(0, 127);
            x1 = x0 + $urandom_range(0, 12); if (x1 > 255) x1 = 255;
            y1 = y0 + $urandom_range(0, 5);  if (y1 > 127) y1 = 127;
            if ($urandom_range(0, 5) == 0) begin
                int tmp;
                tmp = x0; x0 = x1; x1 = tmp - 1; if (x1 < 0) x1 = 0;
            end
            run_cmd(x0, x1, y0, y1, $urandom_range(0, 15), 1, 0, 0, n, fa, la, dc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
